// File: rtl/ps2_bus_monitor.sv
// Passive PS/2 bus observer: decodes device-to-host and host-to-device frames,
// checks parity/stop/ack/timeout and queues tagged entries in a FWFT FIFO.
//
//   state     | meaning
//   IDLE      | bus idle, waiting for a falling clock edge
//   RX_BITS   | device-to-host frame, sampling on falling edges
//   INHIBIT   | host holding clock low, measuring request-to-send
//   TX_BITS   | host-to-device frame, sampling on rising edges
//   TX_ACK    | waiting for the device acknowledge on the next fall
`timescale 1ns/1ps
module ps2_bus_monitor #(
  parameter int FILTER_LEN     = 8,
  parameter int INHIBIT_MIN    = 5000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_AW        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2c,
  input  logic               ps2d,
  input  logic               rd_en,
  output logic [10:0]        rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  output logic               frame_tick
);

  localparam int PH_MAX = (INHIBIT_MIN > TIMEOUT_CYCLES) ? INHIBIT_MIN : TIMEOUT_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);
  localparam int DEPTH  = 2 ** FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_RX_BITS, S_INHIBIT, S_TX_BITS, S_TX_ACK} state_t;

  logic            r_c_meta, r_c_sync, r_d_meta, r_d_sync;
  logic            r_c_filt, r_d_filt, r_c_prev;
  logic [FL_W-1:0] r_c_cnt, r_d_cnt;
  logic [PH_W-1:0] r_phase;
  logic            w_fall, w_rise, w_timeout, w_inhibit_ok, w_bit_edge;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            r_par_bad, w_par_bad_nxt, r_stop_bad, w_stop_bad_nxt;
  logic            r_push, w_push_nxt;
  logic [10:0]     r_push_data, w_push_data_nxt;

  logic [10:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;
  logic               w_empty, w_full, w_pop, w_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_meta <= 1'b1; r_c_sync <= 1'b1;
      r_d_meta <= 1'b1; r_d_sync <= 1'b1;
    end else begin
      r_c_meta <= ps2c; r_c_sync <= r_c_meta;
      r_d_meta <= ps2d; r_d_sync <= r_d_meta;
    end
  end

  // a line only changes after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_cnt  <= '0;
      r_c_filt <= 1'b1;
    end else if (r_c_sync == r_c_filt) begin
      r_c_cnt  <= '0;
    end else if (r_c_cnt == FL_W'(FILTER_LEN - 1)) begin
      r_c_filt <= r_c_sync;
      r_c_cnt  <= '0;
    end else begin
      r_c_cnt  <= r_c_cnt + FL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_cnt  <= '0;
      r_d_filt <= 1'b1;
    end else if (r_d_sync == r_d_filt) begin
      r_d_cnt  <= '0;
    end else if (r_d_cnt == FL_W'(FILTER_LEN - 1)) begin
      r_d_filt <= r_d_sync;
      r_d_cnt  <= '0;
    end else begin
      r_d_cnt  <= r_d_cnt + FL_W'(1);
    end
  end

  assign w_fall = r_c_prev & ~r_c_filt;
  assign w_rise = ~r_c_prev & r_c_filt;

  // the edge cycle itself counts as the first cycle of the new phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_prev <= 1'b1;
      r_phase  <= '0;
    end else begin
      r_c_prev <= r_c_filt;
      if (w_fall || w_rise)
        r_phase <= PH_W'(1);
      else if (r_phase != PH_W'(PH_MAX))
        r_phase <= r_phase + PH_W'(1);
    end
  end

  assign w_timeout    = (r_phase == PH_W'(TIMEOUT_CYCLES));
  assign w_inhibit_ok = (r_phase >= PH_W'(INHIBIT_MIN));
  assign w_bit_edge   = (r_state == S_RX_BITS) ? w_fall : w_rise;

  function automatic logic [1:0] f_err(input logic par_bad, input logic frame_bad);
    if (par_bad)        return 2'd1;
    else if (frame_bad) return 2'd2;
    else                return 2'd0;
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_nxt       = r_bit;
    w_data_nxt      = r_data;
    w_par_bad_nxt   = r_par_bad;
    w_stop_bad_nxt  = r_stop_bad;
    w_push_nxt      = 1'b0;
    w_push_data_nxt = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_bit_nxt      = '0;
          w_data_nxt     = '0;
          w_par_bad_nxt  = 1'b0;
          w_stop_bad_nxt = 1'b0;
          w_state_nxt    = r_d_filt ? S_INHIBIT : S_RX_BITS;
        end
      end
      S_INHIBIT: begin
        if (w_rise)
          w_state_nxt = (w_inhibit_ok && !r_d_filt) ? S_TX_BITS : S_IDLE;
      end
      S_RX_BITS, S_TX_BITS: begin
        if (w_timeout) begin
          w_push_nxt      = 1'b1;
          w_push_data_nxt = {(r_state == S_TX_BITS), 2'd3, r_data};
          w_state_nxt     = S_IDLE;
        end else if (w_bit_edge) begin
          w_bit_nxt = r_bit + 4'd1;
          if (r_bit < 4'd8) begin
            w_data_nxt[r_bit[2:0]] = r_d_filt;
          end else if (r_bit == 4'd8) begin
            w_par_bad_nxt = ~^{r_data, r_d_filt};
          end else begin
            w_stop_bad_nxt = ~r_d_filt;
            if (r_state == S_RX_BITS) begin
              w_push_nxt      = 1'b1;
              w_push_data_nxt = {1'b0, f_err(r_par_bad, ~r_d_filt), r_data};
              w_state_nxt     = S_IDLE;
            end else begin
              w_state_nxt = S_TX_ACK;
            end
          end
        end
      end
      S_TX_ACK: begin
        if (w_timeout) begin
          w_push_nxt      = 1'b1;
          w_push_data_nxt = {1'b1, 2'd3, r_data};
          w_state_nxt     = S_IDLE;
        end else if (w_fall) begin
          w_push_nxt      = 1'b1;
          w_push_data_nxt = {1'b1, f_err(r_par_bad, r_stop_bad | r_d_filt), r_data};
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit       <= '0;
      r_data      <= '0;
      r_par_bad   <= 1'b0;
      r_stop_bad  <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit       <= w_bit_nxt;
      r_data      <= w_data_nxt;
      r_par_bad   <= w_par_bad_nxt;
      r_stop_bad  <= w_stop_bad_nxt;
      r_push      <= w_push_nxt;
      r_push_data <= w_push_data_nxt;
    end
  end

  // a pop frees the head slot, so a push while full is accepted alongside it
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (FIFO_AW + 1)'(DEPTH));
  assign w_pop   = rd_en & ~w_empty;
  assign w_wr    = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (FIFO_AW + 1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (FIFO_AW + 1)'(1);
      if (r_push && !w_wr)     r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
  end

  assign rd_data    = w_empty ? 11'd0 : r_mem[r_rd_ptr];
  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign frame_tick = r_push;

endmodule

// File: tb/tb_ps2_bus_monitor.sv
// Directed bench for ps2_bus_monitor: drives device and host frames on the raw
// pins and compares popped FIFO entries against hand-computed values.
`timescale 1ns/1ps
module tb_ps2_bus_monitor;

  localparam int FILTER_LEN     = 4;
  localparam int INHIBIT_MIN    = 60;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int FIFO_AW        = 2;
  localparam int HALF           = 20;

  logic             clk = 1'b0;
  logic             reset, ps2c, ps2d, rd_en;
  logic [10:0]      rd_data;
  logic             empty, full, overflow, frame_tick;
  logic [FIFO_AW:0] count;

  int n_checks = 0;
  int n_errors = 0;
  int n_ticks  = 0;
  int t0;

  always #5 clk = ~clk;

  ps2_bus_monitor #(
    .FILTER_LEN(FILTER_LEN), .INHIBIT_MIN(INHIBIT_MIN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FIFO_AW(FIFO_AW)
  ) u_dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .frame_tick(frame_tick)
  );

  always @(negedge clk) if (frame_tick) n_ticks++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // device-to-host: nbits of {stop, par, data, start} sent LSB (start) first
  task automatic dev_frame(input logic [7:0] d, input logic par, input logic stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      wait_cyc(HALF); ps2c = 1'b0;
      wait_cyc(HALF); ps2c = 1'b1;
    end
    wait_cyc(HALF); ps2d = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic host_inhibit(input int low_len);
    ps2c = 1'b0;
    wait_cyc(low_len / 2); ps2d = 1'b0;
    wait_cyc(low_len - low_len / 2); ps2c = 1'b1;
  endtask

  // host request-to-send, then the bench plays the device clock and ack
  task automatic host_frame(input logic [7:0] d, input logic ack);
    logic [9:0] bits;
    bits = {1'b1, odd_par(d), d};
    host_inhibit(INHIBIT_MIN);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(HALF);     ps2c = 1'b0;
      wait_cyc(HALF / 2); ps2d = bits[i];
      wait_cyc(HALF / 2); ps2c = 1'b1;
    end
    wait_cyc(HALF / 2); ps2d = ~ack;
    wait_cyc(HALF / 2); ps2c = 1'b0;
    wait_cyc(HALF);     ps2c = 1'b1;
    wait_cyc(HALF / 2); ps2d = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic pop_check(input string tag, input logic [10:0] exp);
    check_eq(tag, rd_data, exp);
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rd_en = 1'b0;
    wait_cyc(5);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_tick", frame_tick, 0);
    check_eq("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    wait_cyc(5);

    t0 = n_ticks;
    dev_frame(8'h1C, 1'b0, 1'b1, 11);
    check_eq("d2h_ticks", n_ticks - t0, 1);
    check_eq("d2h_count", count, 1);
    pop_check("d2h_1c", 11'h01C);
    check_eq("d2h_empty_after_pop", empty, 1);

    host_frame(8'hED, 1'b1);
    pop_check("h2d_ed_ack", 11'h4ED);
    host_frame(8'hED, 1'b0);
    pop_check("h2d_ed_noack", 11'h6ED);

    // 0xAA has four ones; parity 0 leaves an even total, which is a parity error
    dev_frame(8'hAA, 1'b0, 1'b1, 11);
    pop_check("d2h_parity", 11'h1AA);
    dev_frame(8'h55, 1'b1, 1'b0, 11);
    pop_check("d2h_stop", 11'h255);

    t0 = n_ticks;
    host_inhibit(INHIBIT_MIN - 1);
    wait_cyc(HALF); ps2d = 1'b1;
    wait_cyc(HALF);
    check_eq("short_inhibit_ticks", n_ticks - t0, 0);
    check_eq("short_inhibit_empty", empty, 1);

    t0 = n_ticks;
    ps2d = 1'b0; wait_cyc(10);
    ps2c = 1'b0; wait_cyc(FILTER_LEN - 1); ps2c = 1'b1;
    wait_cyc(10); ps2d = 1'b1; wait_cyc(HALF);
    dev_frame(8'h3A, odd_par(8'h3A), 1'b1, 11);
    check_eq("glitch_ticks", n_ticks - t0, 1);
    pop_check("glitch_3a", 11'h03A);

    t0 = n_ticks;
    dev_frame(8'h0F, 1'b0, 1'b1, 5);
    wait_cyc(TIMEOUT_CYCLES - 100);
    check_eq("timeout_early", n_ticks - t0, 0);
    wait_cyc(150);
    check_eq("timeout_ticks", n_ticks - t0, 1);
    pop_check("timeout_0f", 11'h30F);

    t0 = n_ticks;
    for (int k = 1; k <= 5; k++)
      dev_frame(8'(k), odd_par(8'(k)), 1'b1, 11);
    check_eq("ovf_ticks", n_ticks - t0, 5);
    check_eq("ovf_full", full, 1);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_count", count, 4);

    seen = 1'b0;
    fork
      dev_frame(8'h06, odd_par(8'h06), 1'b1, 11);
      begin
        for (int c = 0; c < 2000 && !seen; c++) begin
          @(negedge clk);
          if (frame_tick) seen = 1'b1;
        end
        if (seen) begin
          rd_en = 1'b1;
          wait_cyc(1);
          rd_en = 1'b0;
        end
      end
    join
    check_eq("pp_tick_seen", seen, 1);
    check_eq("pp_count", count, 4);
    check_eq("pp_full", full, 1);
    pop_check("pp_e2", 11'h002);
    pop_check("pp_e3", 11'h003);
    pop_check("pp_e4", 11'h004);
    pop_check("pp_e6", 11'h006);
    check_eq("pp_empty", empty, 1);
    check_eq("pp_rd_data_zero", rd_data, 0);
    check_eq("pp_overflow_sticky", overflow, 1);

    dev_frame(8'h1C, 1'b0, 1'b1, 11);
    dev_frame(8'h77, 1'b0, 1'b1, 4);
    reset = 1'b1; wait_cyc(3); reset = 1'b0;
    wait_cyc(HALF);
    check_eq("midrst_count", count, 0);
    check_eq("midrst_empty", empty, 1);
    check_eq("midrst_overflow", overflow, 0);
    dev_frame(8'h1C, 1'b0, 1'b1, 11);
    check_eq("midrst_count_after", count, 1);
    pop_check("midrst_1c", 11'h01C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
